xbox_mem_arb: RTL and testbench

- Round-robin arbiter sharing one XBOX mastered memory port among NUM_REQ accelerator engines, for example the MatMul engine and a copy/DMA engine.
- Sits between the engines' xlr_mem-style request ports and one xlr_mem_* instance.
- Supports lock ownership so an engine can complete an atomic read-calc-write sequence without interleaving.
- Lock hold time is bounded by a timeout.

---
 rtl/xbox_pkg.sv | 18 +
 rtl/xbox_mem_arb_if.sv | 55 +++++
 rtl/xbox_mem_arb_rr_pick.sv | 42 ++++
 rtl/xbox_mem_arb.sv | 127 ++++++++++++
 tb/tb_xbox_mem_arb.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/xbox_pkg.sv
// Shared definitions for the XBOX memory-port arbiter.
//   XBOX_WORDS / WORD_W / BE_W : geometry of one memory line
//   arb_state_t                : arbiter FSM state (2-bit encoding)
//   mem_line_t                 : one memory line, XBOX_WORDS x WORD_W bits
package xbox_pkg;

  localparam int XBOX_WORDS = 8;
  localparam int WORD_W     = 32;
  localparam int BE_W       = 32;

  typedef enum logic [1:0] {
    ARB    = 2'd0,
    LOCKED = 2'd1
  } arb_state_t;

  typedef logic [XBOX_WORDS-1:0][WORD_W-1:0] mem_line_t;

endpackage

// File: rtl/xbox_mem_arb_if.sv
// Bundle of every bus signal around the arbiter: the NUM_REQ engine request
// ports, the single shared xlr_mem port and the arbiter status outputs.
//   modport slave  : the arbiter itself
//   modport master : the environment (engines plus the memory)
interface xbox_mem_arb_if #(
  parameter int NUM_REQ            = 2,
  parameter int LOG2_LINES_PER_MEM = 4
);
  import xbox_pkg::*;

  localparam int IDX_W = $clog2(NUM_REQ);

  // engine side
  logic [NUM_REQ-1:0]                         req_valid;
  logic [NUM_REQ-1:0]                         req_rd;
  logic [NUM_REQ-1:0]                         req_wr;
  logic [NUM_REQ-1:0]                         req_lock;
  logic [NUM_REQ-1:0][LOG2_LINES_PER_MEM-1:0] req_addr;
  mem_line_t [NUM_REQ-1:0]                    req_wdata;
  logic [NUM_REQ-1:0][BE_W-1:0]               req_be;
  logic [NUM_REQ-1:0]                         req_ready;
  logic [NUM_REQ-1:0]                         rsp_valid;
  mem_line_t                                  rsp_rdata;

  // memory side
  logic [LOG2_LINES_PER_MEM-1:0]              xlr_mem_addr;
  mem_line_t                                  xlr_mem_wdata;
  logic [BE_W-1:0]                            xlr_mem_be;
  logic                                       xlr_mem_rd;
  logic                                       xlr_mem_wr;
  mem_line_t                                  xlr_mem_rdata;

  // status
  logic [IDX_W-1:0]                           owner;
  logic                                       locked;
  logic                                       lock_timeout;
  logic [NUM_REQ-1:0]                         illegal_req;

  modport slave (
    input  req_valid, req_rd, req_wr, req_lock, req_addr, req_wdata, req_be,
    input  xlr_mem_rdata,
    output req_ready, rsp_valid, rsp_rdata,
    output xlr_mem_addr, xlr_mem_wdata, xlr_mem_be, xlr_mem_rd, xlr_mem_wr,
    output owner, locked, lock_timeout, illegal_req
  );

  modport master (
    output req_valid, req_rd, req_wr, req_lock, req_addr, req_wdata, req_be,
    output xlr_mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata,
    input  xlr_mem_addr, xlr_mem_wdata, xlr_mem_be, xlr_mem_rd, xlr_mem_wr,
    input  owner, locked, lock_timeout, illegal_req
  );

endinterface

// File: rtl/xbox_mem_arb_rr_pick.sv
// Rotating-priority picker (rr_pick): purely combinational.
//   i_eligible  : requesters that may be granted this cycle
//   i_rr_ptr    : index holding highest priority; search goes upward and wraps
//   o_grant_oh  : one-hot grant
//   o_grant_idx : binary index of the grant
//   o_any       : some requester was picked
module xbox_mem_arb_rr_pick #(
  parameter  int N     = 2,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     i_eligible,
  input  logic [IDX_W-1:0] i_rr_ptr,
  output logic [N-1:0]     o_grant_oh,
  output logic [IDX_W-1:0] o_grant_idx,
  output logic             o_any
);

  logic [IDX_W:0]   w_sum;
  logic [IDX_W-1:0] w_idx;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would infer a latch.
    o_grant_oh  = '0;
    o_grant_idx = '0;
    o_any       = 1'b0;
    w_sum       = '0;
    w_idx       = '0;
    for (int k = 0; k < N; k++) begin
      // candidate = (rr_ptr + k) mod N, kept one bit wider to catch the wrap
      w_sum = {1'b0, i_rr_ptr} + (IDX_W+1)'(k);
      if (w_sum >= (IDX_W+1)'(N)) w_sum = w_sum - (IDX_W+1)'(N);
      w_idx = w_sum[IDX_W-1:0];
      if (!o_any && i_eligible[w_idx]) begin
        o_any             = 1'b1;
        o_grant_idx       = w_idx;
        o_grant_oh[w_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/xbox_mem_arb.sv
// Round-robin arbiter sharing one xlr_mem port among NUM_REQ engines, with
// lock ownership for atomic read-modify-write sequences and a lock timeout.
//   clk, rst : clock and synchronous active-high reset
//   bus      : engine request ports, shared memory port and status outputs
//              (see xbox_mem_arb_if)
// Accesses issue combinationally in the grant cycle; read responses return on
// rsp_valid one cycle later with rsp_rdata passed straight from memory.
module xbox_mem_arb
  import xbox_pkg::*;
#(
  parameter int NUM_REQ            = 2,
  parameter int LOG2_LINES_PER_MEM = 4,
  parameter int LOCK_MAX           = 16
) (
  input  logic           clk,
  input  logic           rst,
  xbox_mem_arb_if.slave  bus
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(LOCK_MAX);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_MAX - 1);

  arb_state_t         r_state, w_state_nxt;
  logic [IDX_W-1:0]   r_rr_ptr, r_owner, w_grant_idx;
  logic [CNT_W-1:0]   r_lock_cnt;
  logic [NUM_REQ-1:0] r_rsp_valid;
  logic [NUM_REQ-1:0] w_legal, w_eligible, w_grant_oh, w_ready, w_owner_mask;
  logic               w_any, w_grant, w_owner_lock, w_timeout;

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i_idx);
    return (i_idx == IDX_W'(NUM_REQ - 1)) ? '0 : i_idx + 1'b1;
  endfunction

  assign w_legal         = bus.req_valid & (bus.req_rd ^ bus.req_wr);
  assign bus.illegal_req = bus.req_valid & ~(bus.req_rd ^ bus.req_wr);
  assign w_owner_mask    = NUM_REQ'(1) << r_owner;
  assign w_owner_lock    = bus.req_lock[r_owner];

  xbox_mem_arb_rr_pick #(.N(NUM_REQ)) u_rr_pick (
    .i_eligible  (w_eligible),
    .i_rr_ptr    (r_rr_ptr),
    .o_grant_oh  (w_grant_oh),
    .o_grant_idx (w_grant_idx),
    .o_any       (w_any)
  );

  // Nothing issues while reset is asserted.
  assign w_grant = w_any & ~rst;
  assign w_ready = w_grant ? w_grant_oh : '0;

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) r_state <= ARB;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic. Release is checked every locked cycle, with or without
  // an access, so an idle owner dropping req_lock frees the port at once.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ARB:     if (w_grant && bus.req_lock[w_grant_idx]) w_state_nxt = LOCKED;
      LOCKED:  if (!w_owner_lock || r_lock_cnt == CNT_LAST) w_state_nxt = ARB;
      default: w_state_nxt = ARB;
    endcase
  end

  // Output logic. A timeout is only a forced release: an owner dropping
  // req_lock on the last allowed cycle is an ordinary release.
  always_comb begin
    w_eligible = w_legal;
    w_timeout  = 1'b0;
    case (r_state)
      ARB:     w_eligible = w_legal;
      LOCKED: begin
        w_eligible = w_legal & w_owner_mask;
        w_timeout  = w_owner_lock && (r_lock_cnt == CNT_LAST);
      end
      default: w_eligible = '0;
    endcase
  end

  // Pointer, owner, lock counter and read-response pipeline
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr    <= '0;
      r_owner     <= '0;
      r_lock_cnt  <= '0;
      r_rsp_valid <= '0;
    end else begin
      if (w_grant)        r_rr_ptr <= wrap_inc(w_grant_idx);
      else if (w_timeout) r_rr_ptr <= wrap_inc(r_owner);
      if (w_grant) r_owner <= w_grant_idx;
      // counts cycles spent in LOCKED; zero on entry
      r_lock_cnt  <= (r_state == LOCKED && w_state_nxt == LOCKED) ?
                     r_lock_cnt + 1'b1 : '0;
      r_rsp_valid <= w_ready & bus.req_rd;
    end
  end

  // Memory drive: granted requester's fields, otherwise all zero
  always_comb begin
    bus.xlr_mem_addr  = '0;
    bus.xlr_mem_wdata = '0;
    bus.xlr_mem_be    = '0;
    bus.xlr_mem_rd    = 1'b0;
    bus.xlr_mem_wr    = 1'b0;
    if (w_grant) begin
      bus.xlr_mem_addr  = bus.req_addr[w_grant_idx];
      bus.xlr_mem_wdata = bus.req_wdata[w_grant_idx];
      bus.xlr_mem_be    = bus.req_be[w_grant_idx];
      bus.xlr_mem_rd    = bus.req_rd[w_grant_idx];
      bus.xlr_mem_wr    = bus.req_wr[w_grant_idx];
    end
  end

  assign bus.req_ready    = w_ready;
  assign bus.rsp_valid    = r_rsp_valid;
  assign bus.rsp_rdata    = bus.xlr_mem_rdata;
  assign bus.owner        = r_owner;
  assign bus.locked       = (r_state == LOCKED);
  assign bus.lock_timeout = w_timeout & ~rst;

endmodule

// File: tb/tb_xbox_mem_arb.sv
// Directed bench for xbox_mem_arb with two engines and LOCK_MAX=4. A table
// of per-cycle {inputs, expected outputs} rows covers read, round-robin,
// locked read-modify-write and illegal requests; hand-written sequences
// cover the lock timeout and reset in the middle of a locked sequence.
module tb_xbox_mem_arb;
  import xbox_pkg::*;

  localparam int NR = 2;
  localparam int AW = 4;
  localparam int LM = 4;
  localparam logic [31:0] BE0 = 32'h0000_FFFF;
  localparam logic [31:0] BE1 = 32'hFFFF_0000;

  logic clk;
  logic rst;

  xbox_mem_arb_if #(.NUM_REQ(NR), .LOG2_LINES_PER_MEM(AW)) bus ();

  xbox_mem_arb #(.NUM_REQ(NR), .LOG2_LINES_PER_MEM(AW), .LOCK_MAX(LM)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memory model: one-cycle read latency ----------------
  mem_line_t mem [16];
  mem_line_t rdata_q;
  assign bus.xlr_mem_rdata = rdata_q;

  function automatic mem_line_t line_pat(input int l);
    mem_line_t v;
    for (int w = 0; w < 8; w++)
      v[w] = (l == 3) ? 32'h11 + 32'(w) : (32'hA000_0000 | 32'(l << 8) | 32'(w));
    return v;
  endfunction

  function automatic mem_line_t wdat(input int e);
    mem_line_t v;
    for (int w = 0; w < 8; w++) v[w] = 32'hD000_0000 | 32'(e << 8) | 32'(w);
    return v;
  endfunction

  always @(posedge clk) begin
    mem_line_t t;
    if (bus.xlr_mem_rd) rdata_q <= mem[bus.xlr_mem_addr];
    if (bus.xlr_mem_wr) begin
      t = mem[bus.xlr_mem_addr];
      for (int b = 0; b < 32; b++)
        if (bus.xlr_mem_be[b]) t[b/4][8*(b%4) +: 8] = bus.xlr_mem_wdata[b/4][8*(b%4) +: 8];
      mem[bus.xlr_mem_addr] <= t;
    end
  end

  // ---------------- checking ----------------
  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [1:0] v, rd, wr, lk,
                       input logic [3:0] a0, a1);
    rst              = r;
    bus.req_valid    = v;
    bus.req_rd       = rd;
    bus.req_wr       = wr;
    bus.req_lock     = lk;
    bus.req_addr[0]  = a0;
    bus.req_addr[1]  = a1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       rst;
    logic [1:0] v, rd, wr, lk;
    logic [3:0] a0, a1;
    logic [1:0] e_rdy, e_rsp, e_ill;
    logic       e_mrd, e_mwr;
    logic [3:0] e_maddr;
    logic       e_lkd, e_to, e_own, e_rchk;
    logic [3:0] e_rline;
  } vec_t;

  function automatic vec_t mk(
      input logic r, input logic [1:0] v, rd, wr, lk, input logic [3:0] a0, a1,
      input logic [1:0] e_rdy, e_rsp, e_ill, input logic e_mrd, e_mwr,
      input logic [3:0] e_maddr, input logic e_lkd, e_to, e_own, e_rchk,
      input logic [3:0] e_rline);
    vec_t x;
    x.rst = r; x.v = v; x.rd = rd; x.wr = wr; x.lk = lk; x.a0 = a0; x.a1 = a1;
    x.e_rdy = e_rdy; x.e_rsp = e_rsp; x.e_ill = e_ill; x.e_mrd = e_mrd;
    x.e_mwr = e_mwr; x.e_maddr = e_maddr; x.e_lkd = e_lkd; x.e_to = e_to;
    x.e_own = e_own; x.e_rchk = e_rchk; x.e_rline = e_rline;
    return x;
  endfunction

  localparam int NV = 22;
  vec_t tbl [NV];

  initial begin
    #50000;
    $display("FAIL watchdog: bench did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    mem_line_t exp_wd;
    logic [31:0] exp_be;

    for (int l = 0; l < 16; l++) mem[l] = line_pat(l);
    rdata_q          = '0;
    bus.req_wdata[0] = wdat(0);
    bus.req_wdata[1] = wdat(1);
    bus.req_be[0]    = BE0;
    bus.req_be[1]    = BE1;

    //             rst v     rd    wr    lk    a0 a1 | rdy   rsp   ill   mrd mwr ma lkd to own rchk rl
    // reset held, then single read of line 3
    tbl[0]  = mk(1, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0,  2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0,  2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[2]  = mk(0, 2'b01, 2'b01, 2'b00, 2'b00, 3, 0,  2'b01, 2'b00, 2'b00, 1, 0, 3, 0, 0, 0, 0, 0);
    tbl[3]  = mk(0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0,  2'b00, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 1, 3);
    // req1 alone moves rr_ptr back to 0
    tbl[4]  = mk(0, 2'b10, 2'b10, 2'b00, 2'b00, 0, 5,  2'b10, 2'b00, 2'b00, 1, 0, 5, 0, 0, 0, 0, 0);
    // both reading continuously: 0,1,0,1,0,1
    tbl[5]  = mk(0, 2'b11, 2'b11, 2'b00, 2'b00, 1, 2,  2'b01, 2'b10, 2'b00, 1, 0, 1, 0, 0, 1, 1, 5);
    tbl[6]  = mk(0, 2'b11, 2'b11, 2'b00, 2'b00, 1, 2,  2'b10, 2'b01, 2'b00, 1, 0, 2, 0, 0, 0, 1, 1);
    tbl[7]  = mk(0, 2'b11, 2'b11, 2'b00, 2'b00, 1, 2,  2'b01, 2'b10, 2'b00, 1, 0, 1, 0, 0, 1, 1, 2);
    tbl[8]  = mk(0, 2'b11, 2'b11, 2'b00, 2'b00, 1, 2,  2'b10, 2'b01, 2'b00, 1, 0, 2, 0, 0, 0, 1, 1);
    tbl[9]  = mk(0, 2'b11, 2'b11, 2'b00, 2'b00, 1, 2,  2'b01, 2'b10, 2'b00, 1, 0, 1, 0, 0, 1, 1, 2);
    tbl[10] = mk(0, 2'b11, 2'b11, 2'b00, 2'b00, 1, 2,  2'b10, 2'b01, 2'b00, 1, 0, 2, 0, 0, 0, 1, 1);
    tbl[11] = mk(0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0,  2'b00, 2'b10, 2'b00, 0, 0, 0, 0, 0, 1, 1, 2);
    tbl[12] = mk(0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0,  2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 0, 0);
    // locked read-modify-write by req0 while req1 keeps asking
    tbl[13] = mk(0, 2'b11, 2'b11, 2'b00, 2'b01, 0, 2,  2'b01, 2'b00, 2'b00, 1, 0, 0, 0, 0, 1, 0, 0);
    tbl[14] = mk(0, 2'b10, 2'b10, 2'b00, 2'b01, 0, 2,  2'b00, 2'b01, 2'b00, 0, 0, 0, 1, 0, 0, 1, 0);
    tbl[15] = mk(0, 2'b10, 2'b10, 2'b00, 2'b01, 0, 2,  2'b00, 2'b00, 2'b00, 0, 0, 0, 1, 0, 0, 0, 0);
    tbl[16] = mk(0, 2'b11, 2'b10, 2'b01, 2'b00, 1, 2,  2'b01, 2'b00, 2'b00, 0, 1, 1, 1, 0, 0, 0, 0);
    tbl[17] = mk(0, 2'b10, 2'b10, 2'b00, 2'b00, 0, 2,  2'b10, 2'b00, 2'b00, 1, 0, 2, 0, 0, 0, 0, 0);
    tbl[18] = mk(0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0,  2'b00, 2'b10, 2'b00, 0, 0, 0, 0, 0, 1, 1, 2);
    // illegal req0 (rd=wr=1) next to a legal write from req1
    tbl[19] = mk(0, 2'b11, 2'b01, 2'b11, 2'b00, 0, 7,  2'b10, 2'b00, 2'b01, 0, 1, 7, 0, 0, 1, 0, 0);
    tbl[20] = mk(0, 2'b01, 2'b00, 2'b00, 2'b00, 0, 0,  2'b00, 2'b00, 2'b01, 0, 0, 0, 0, 0, 1, 0, 0);
    tbl[21] = mk(0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0,  2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 0, 0);

    drive(1, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0);
    tick();
    tick();

    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].rst, tbl[i].v, tbl[i].rd, tbl[i].wr, tbl[i].lk, tbl[i].a0, tbl[i].a1);
      exp_be = (tbl[i].e_rdy == 2'b01) ? BE0 : (tbl[i].e_rdy == 2'b10) ? BE1 : 32'h0;
      exp_wd = (tbl[i].e_rdy == 2'b01) ? wdat(0) : (tbl[i].e_rdy == 2'b10) ? wdat(1) : '0;
      @(negedge clk);
      check($sformatf("v%0d req_ready", i),    256'(bus.req_ready),    256'(tbl[i].e_rdy));
      check($sformatf("v%0d rsp_valid", i),    256'(bus.rsp_valid),    256'(tbl[i].e_rsp));
      check($sformatf("v%0d illegal_req", i),  256'(bus.illegal_req),  256'(tbl[i].e_ill));
      check($sformatf("v%0d xlr_mem_rd", i),   256'(bus.xlr_mem_rd),   256'(tbl[i].e_mrd));
      check($sformatf("v%0d xlr_mem_wr", i),   256'(bus.xlr_mem_wr),   256'(tbl[i].e_mwr));
      check($sformatf("v%0d xlr_mem_addr", i), 256'(bus.xlr_mem_addr), 256'(tbl[i].e_maddr));
      check($sformatf("v%0d xlr_mem_be", i),   256'(bus.xlr_mem_be),   256'(exp_be));
      check($sformatf("v%0d xlr_mem_wdata", i), 256'(bus.xlr_mem_wdata), 256'(exp_wd));
      check($sformatf("v%0d locked", i),       256'(bus.locked),       256'(tbl[i].e_lkd));
      check($sformatf("v%0d lock_timeout", i), 256'(bus.lock_timeout), 256'(tbl[i].e_to));
      check($sformatf("v%0d owner", i),        256'(bus.owner),        256'(tbl[i].e_own));
      if (tbl[i].e_rchk)
        check($sformatf("v%0d rsp_rdata", i), 256'(bus.rsp_rdata), 256'(line_pat(int'(tbl[i].e_rline))));
      tick();
    end

    // ---- lock timeout: req0 locks and never lets go, req1 keeps asking ----
    drive(0, 2'b11, 2'b11, 2'b00, 2'b01, 4, 6);
    @(negedge clk);
    check("to grant0 req_ready", 256'(bus.req_ready), 256'(2'b01));
    check("to grant0 locked",    256'(bus.locked),    256'(1'b0));
    tick();
    for (int k = 0; k < LM; k++) begin
      drive(0, 2'b10, 2'b10, 2'b00, 2'b01, 4, 6);
      @(negedge clk);
      check($sformatf("to hold%0d req_ready", k),    256'(bus.req_ready),    256'(2'b00));
      check($sformatf("to hold%0d locked", k),       256'(bus.locked),       256'(1'b1));
      check($sformatf("to hold%0d lock_timeout", k), 256'(bus.lock_timeout), 256'(k == LM - 1));
      tick();
    end
    drive(0, 2'b10, 2'b10, 2'b00, 2'b01, 4, 6);
    @(negedge clk);
    check("to after req_ready",    256'(bus.req_ready),    256'(2'b10));
    check("to after locked",       256'(bus.locked),       256'(1'b0));
    check("to after lock_timeout", 256'(bus.lock_timeout), 256'(1'b0));
    tick();
    drive(0, 2'b11, 2'b11, 2'b00, 2'b00, 4, 6);
    @(negedge clk);
    check("to rr_wrap req_ready", 256'(bus.req_ready), 256'(2'b01));
    check("to rr_wrap rsp_valid", 256'(bus.rsp_valid), 256'(2'b10));
    tick();
    drive(0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0);
    tick();

    // ---- reset while locked, in the cycle after a read issue ----
    drive(0, 2'b01, 2'b01, 2'b00, 2'b01, 2, 0);
    @(negedge clk);
    check("rst lock req_ready", 256'(bus.req_ready), 256'(2'b01));
    tick();
    drive(0, 2'b01, 2'b01, 2'b00, 2'b01, 3, 0);
    @(negedge clk);
    check("rst rd req_ready", 256'(bus.req_ready), 256'(2'b01));
    check("rst rd locked",    256'(bus.locked),    256'(1'b1));
    tick();
    drive(1, 2'b11, 2'b11, 2'b00, 2'b01, 3, 5);
    @(negedge clk);
    check("rst c0 req_ready",  256'(bus.req_ready),  256'(2'b00));
    check("rst c0 xlr_mem_rd", 256'(bus.xlr_mem_rd), 256'(1'b0));
    check("rst c0 rsp_valid",  256'(bus.rsp_valid),  256'(2'b01));
    check("rst c0 locked",     256'(bus.locked),     256'(1'b1));
    tick();
    drive(1, 2'b11, 2'b11, 2'b00, 2'b01, 3, 5);
    @(negedge clk);
    check("rst c1 req_ready",  256'(bus.req_ready),  256'(2'b00));
    check("rst c1 xlr_mem_rd", 256'(bus.xlr_mem_rd), 256'(1'b0));
    check("rst c1 rsp_valid",  256'(bus.rsp_valid),  256'(2'b00));
    check("rst c1 locked",     256'(bus.locked),     256'(1'b0));
    check("rst c1 owner",      256'(bus.owner),      256'(1'b0));
    tick();
    drive(0, 2'b10, 2'b10, 2'b00, 2'b00, 0, 5);
    @(negedge clk);
    check("rst only1 req_ready", 256'(bus.req_ready), 256'(2'b10));
    check("rst only1 rsp_valid", 256'(bus.rsp_valid), 256'(2'b00));
    tick();
    drive(1, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0);
    tick();
    drive(0, 2'b11, 2'b11, 2'b00, 2'b00, 0, 5);
    @(negedge clk);
    check("rst both req_ready", 256'(bus.req_ready), 256'(2'b01));
    check("rst both owner",     256'(bus.owner),     256'(1'b0));
    tick();
    drive(0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0);
    @(negedge clk);
    check("rst both rsp_valid", 256'(bus.rsp_valid), 256'(2'b01));
    check("rst both rsp_rdata", 256'(bus.rsp_rdata), 256'(line_pat(0)));
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
